uart_link_scheduler: RTL

Sequences the shared WideUARTIO link between the host and up to three sandbox processes. It decodes each received command frame into a one-cycle dispatch to the addressed channel and acknowledges it to the UART with `clearDR`. It arbitrates the single transmit path round-robin between the channels' reply requests, and generates error replies for commands addressed to missing channels. It sits between WideUARTIO and the SandboxProcess instances, in place of a direct point-to-point connection.

---
 rtl/uart_link_scheduler_if.sv | 37 +++
 rtl/uart_link_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_link_scheduler_if.sv
// rtl/uart_link_scheduler_if.sv - link bundle between WideUARTIO, the scheduler and the sandbox channels
interface uart_link_scheduler_if #(
    parameter int NREQ = 2
);
    logic                 dataReceived;
    logic [7:0]           control;
    logic [31:0]          inputData;
    logic                 clearDR;
    logic                 transmitting;
    logic                 transmit;
    logic [7:0]           status;
    logic [31:0]          outputData;
    logic [NREQ-1:0]      cmdValid;
    logic [5:0]           cmdOpcode;
    logic [31:0]          cmdData;
    logic [NREQ-1:0]      reqValid;
    logic [8*NREQ-1:0]    reqStatus;
    logic [32*NREQ-1:0]   reqData;
    logic [NREQ-1:0]      reqAck;
    logic                 errOverrun;

    // Scheduler side
    modport master (
        input  dataReceived, control, inputData, transmitting,
        input  reqValid, reqStatus, reqData,
        output clearDR, transmit, status, outputData,
        output cmdValid, cmdOpcode, cmdData, reqAck, errOverrun
    );

    // UART and sandbox side
    modport slave (
        output dataReceived, control, inputData, transmitting,
        output reqValid, reqStatus, reqData,
        input  clearDR, transmit, status, outputData,
        input  cmdValid, cmdOpcode, cmdData, reqAck, errOverrun
    );
endinterface

// File: rtl/uart_link_scheduler.sv
// rtl/uart_link_scheduler.sv - command dispatch and round-robin reply scheduling on the shared UART link
module uart_link_scheduler #(
    parameter int NREQ = 2
) (
    input  logic                  masterClock,
    input  logic                  reset,
    uart_link_scheduler_if.master bus
);
    typedef enum logic {RX_IDLE, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_BUSY, TX_DONE} tx_state_t;

    rx_state_t       rx_state, rx_next;
    tx_state_t       tx_state, tx_next;

    logic            clear_next;
    logic [NREQ-1:0] cmd_valid_next;
    logic [5:0]      cmd_opcode_next;
    logic [31:0]     cmd_data_next;
    logic            rx_chan_ok;

    logic            err_pend, err_set, err_clr, ovr_set;
    logic [7:0]      err_status;
    logic [31:0]     err_data;

    logic [1:0]      rr_ptr, rr_next;
    logic [1:0]      grant_idx;
    logic            grant_found;
    logic [NREQ-1:0] ack_next;
    logic            transmit_next;
    logic [7:0]      status_next;
    logic [31:0]     data_next;

    // Low two status bits of each channel are replaced by the channel code
    logic            unused_status_bits;
    assign unused_status_bits = ^bus.reqStatus;

    assign rx_chan_ok = (int'(bus.control[1:0]) < NREQ);

    // RX next state: dispatch a held frame once, then wait for the UART to drop it
    always_comb begin
        rx_next         = rx_state;
        clear_next      = 1'b0;
        cmd_valid_next  = '0;
        cmd_opcode_next = bus.cmdOpcode;
        cmd_data_next   = bus.cmdData;
        err_set         = 1'b0;
        ovr_set         = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (bus.dataReceived) begin
                    rx_next         = RX_WAIT;
                    clear_next      = 1'b1;
                    cmd_opcode_next = bus.control[7:2];
                    cmd_data_next   = bus.inputData;
                    if (rx_chan_ok) begin
                        for (int j = 0; j < NREQ; j++) begin
                            if (bus.control[1:0] == 2'(j)) cmd_valid_next[j] = 1'b1;
                        end
                    end else if (err_pend) begin
                        ovr_set = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: begin
                if (!bus.dataReceived) rx_next = RX_IDLE;
            end
        endcase
    end

    // RX state and registered dispatch strobes
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            rx_state      <= RX_IDLE;
            bus.clearDR   <= 1'b0;
            bus.cmdValid  <= '0;
            bus.cmdOpcode <= '0;
            bus.cmdData   <= '0;
        end else begin
            rx_state      <= rx_next;
            bus.clearDR   <= clear_next;
            bus.cmdValid  <= cmd_valid_next;
            bus.cmdOpcode <= cmd_opcode_next;
            bus.cmdData   <= cmd_data_next;
        end
    end

    // Single-entry error reply slot; set and clear never coincide since set needs it empty
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            err_pend       <= 1'b0;
            err_status     <= '0;
            err_data       <= '0;
            bus.errOverrun <= 1'b0;
        end else begin
            if (err_set) begin
                err_pend   <= 1'b1;
                err_status <= {bus.control[7:2], 2'b11};
                err_data   <= bus.inputData;
            end else if (err_clr) begin
                err_pend   <= 1'b0;
            end
            if (ovr_set) bus.errOverrun <= 1'b1;
        end
    end

    // TX next state: error reply first, otherwise round-robin from the channel after the last grant
    always_comb begin
        tx_next       = tx_state;
        rr_next       = rr_ptr;
        ack_next      = '0;
        transmit_next = 1'b0;
        status_next   = bus.status;
        data_next     = bus.outputData;
        err_clr       = 1'b0;
        grant_found   = 1'b0;
        grant_idx     = 2'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && bus.reqValid[j] && (j >= int'(rr_ptr))) begin
                grant_found = 1'b1;
                grant_idx   = 2'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && bus.reqValid[j]) begin
                grant_found = 1'b1;
                grant_idx   = 2'(j);
            end
        end
        case (tx_state)
            TX_IDLE: begin
                if (err_pend) begin
                    status_next = err_status;
                    data_next   = err_data;
                    err_clr     = 1'b1;
                    tx_next     = TX_START;
                end else if (grant_found) begin
                    for (int j = 0; j < NREQ; j++) begin
                        if (grant_idx == 2'(j)) begin
                            ack_next[j] = 1'b1;
                            status_next = {bus.reqStatus[8*j+2 +: 6], grant_idx};
                            data_next   = bus.reqData[32*j +: 32];
                        end
                    end
                    rr_next = (int'(grant_idx) + 1 >= NREQ) ? 2'd0 : grant_idx + 2'd1;
                    tx_next = TX_START;
                end
            end
            TX_START: begin
                if (bus.transmitting) tx_next = TX_BUSY;
                else                  transmit_next = 1'b1;
            end
            TX_BUSY: begin
                if (!bus.transmitting) tx_next = TX_DONE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // TX state, pointer and the reply presented to the UART
    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            tx_state       <= TX_IDLE;
            rr_ptr         <= 2'd0;
            bus.reqAck     <= '0;
            bus.transmit   <= 1'b0;
            bus.status     <= '0;
            bus.outputData <= '0;
        end else begin
            tx_state       <= tx_next;
            rr_ptr         <= rr_next;
            bus.reqAck     <= ack_next;
            bus.transmit   <= transmit_next;
            bus.status     <= status_next;
            bus.outputData <= data_next;
        end
    end
endmodule
